transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/transmitter_pkg.sv | 21 ++
 rtl/transmit_protocol.sv | 50 +++++
 rtl/transmitter.sv | 84 ++++++++
 tb/tb_transmitter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/transmitter_pkg.sv
// Shared constants for the 55-bit serial transmitter: frame geometry,
// FSM state encoding and the parity helper.
package transmitter_pkg;

  localparam int PKT_W      = 55;
  localparam int FRAME_BITS = 58;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PKT_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [PKT_W-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/transmit_protocol.sv
// Framing datapath: holds the latched packet, shifts it out MSB first,
// counts data bits and keeps the parity of the packet as it was latched.
module transmit_protocol
  import transmitter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [PKT_W-1:0] i_data,
  input  logic             i_clear,
  input  logic             i_shift,
  output logic             o_msb,
  output logic             o_next_msb,
  output logic             o_parity,
  output logic             o_last
);

  logic [PKT_W-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_parity;

  // Parity is captured at load so later TX_Data changes cannot disturb it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_data;
      r_parity <= even_parity(i_data);
    end else if (i_shift) begin
      r_shift  <= {r_shift[PKT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_shift) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_msb      = r_shift[PKT_W-1];
  assign o_next_msb = r_shift[PKT_W-2];
  assign o_parity   = r_parity;
  assign o_last     = (r_cnt == LAST_BIT);

endmodule

// File: rtl/transmitter.sv
// Serial transmitter top: valid/ready handshake and frame state machine.
// S_Data is registered from the bit the next state will present.
module transmitter
  import transmitter_pkg::*;
(
  input  logic             Clk_S,
  input  logic             Rst_n,
  input  logic [PKT_W-1:0] TX_Data,
  input  logic             TX_Data_Valid,
  output logic             TX_Ready,
  output logic             S_Data
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       r_sdata;
  logic       w_sdata_next;
  logic       w_accept;
  logic       w_msb;
  logic       w_next_msb;
  logic       w_parity;
  logic       w_last;

  assign w_accept = (r_state == ST_IDLE) && TX_Data_Valid;

  always_comb begin
    w_next_state = ST_IDLE;
    w_sdata_next = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_next_state = w_accept ? ST_START : ST_IDLE;
        w_sdata_next = w_accept ? 1'b0 : 1'b1;
      end
      ST_START: begin
        w_next_state = ST_DATA;
        w_sdata_next = w_msb;
      end
      // The shifter moves on this edge, so the next MSB is the bit below it now.
      ST_DATA: begin
        w_next_state = w_last ? ST_PARITY : ST_DATA;
        w_sdata_next = w_last ? w_parity : w_next_msb;
      end
      ST_PARITY: begin
        w_next_state = ST_STOP;
        w_sdata_next = 1'b1;
      end
      ST_STOP: begin
        w_next_state = ST_IDLE;
        w_sdata_next = 1'b1;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_sdata_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_sdata <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_sdata <= w_sdata_next;
    end
  end

  transmit_protocol u_protocol (
    .i_clk      (Clk_S),
    .i_rst_n    (Rst_n),
    .i_load     (w_accept),
    .i_data     (TX_Data),
    .i_clear    (r_state == ST_START),
    .i_shift    (r_state == ST_DATA),
    .o_msb      (w_msb),
    .o_next_msb (w_next_msb),
    .o_parity   (w_parity),
    .o_last     (w_last)
  );

  assign TX_Ready = (r_state == ST_IDLE);
  assign S_Data   = r_sdata;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: table of packets with hand-computed parity,
// plus back-to-back, data-stability, mid-frame reset and loopback sequences.
module tb_transmitter;

  logic        Clk_S = 1'b0;
  logic        Rst_n = 1'b0;
  logic [54:0] TX_Data = '0;
  logic        TX_Data_Valid = 1'b0;
  logic        TX_Ready;
  logic        S_Data;

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;

  typedef struct {
    logic [54:0] data;
    logic        parity;
  } vec_t;

  vec_t vecs[7];

  transmitter dut (
    .Clk_S         (Clk_S),
    .Rst_n         (Rst_n),
    .TX_Data       (TX_Data),
    .TX_Data_Valid (TX_Data_Valid),
    .TX_Ready      (TX_Ready),
    .S_Data        (S_Data)
  );

  always #5 Clk_S = ~Clk_S;

  always @(posedge Clk_S) cycleCount <= cycleCount + 1;

  // Behavioural receiver, always ready, sampling the line on falling edges.
  int          rxPos = -1;
  logic [54:0] rxShift = '0;
  logic        rxPar = 1'b0;
  logic        rxValid = 1'b0;
  logic [54:0] rxData = '0;

  always @(negedge Clk_S) begin
    rxValid <= 1'b0;
    if (!Rst_n) begin
      rxPos <= -1;
    end else if (rxPos < 0) begin
      if (S_Data == 1'b0) rxPos <= 0;
    end else if (rxPos < 55) begin
      rxShift <= {rxShift[53:0], S_Data};
      rxPos   <= rxPos + 1;
    end else if (rxPos == 55) begin
      rxPar <= S_Data;
      rxPos <= 56;
    end else begin
      if (S_Data == 1'b1 && rxPar == ^rxShift) begin
        rxData  <= rxShift;
        rxValid <= 1'b1;
      end
      rxPos <= -1;
    end
  end

  function automatic logic [57:0] frameOf(input logic [54:0] d, input logic p);
    return {1'b0, d, p, 1'b1};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic waitReady(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk_S);
      if (TX_Ready === 1'b1) seen = 1'b1;
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  // Caller sits at a falling edge with TX_Ready high; the next rising edge accepts.
  task automatic applyStimulus(input logic [54:0] d, input bit holdValid);
    TX_Data       = d;
    TX_Data_Valid = 1'b1;
    @(posedge Clk_S);
    #1;
    if (!holdValid) TX_Data_Valid = 1'b0;
  endtask

  task automatic captureFrame(output logic [57:0] f, output bit readyLow,
                              output int startCycle, input bit toggleValid);
    readyLow   = 1'b1;
    startCycle = 0;
    f          = '0;
    for (int i = 0; i < 58; i++) begin
      @(negedge Clk_S);
      if (i == 0) startCycle = cycleCount;
      f[57-i] = S_Data;
      if (TX_Ready !== 1'b0) readyLow = 1'b0;
      if (toggleValid) TX_Data_Valid = (i == 57) ? 1'b0 : ~TX_Data_Valid;
    end
  endtask

  initial begin
    logic [57:0] f1, f2;
    bit          r1, r2;
    int          s1, s2;
    bit          ok;
    logic [54:0] pkt;

    vecs[0] = '{55'h1, 1'b1};
    vecs[1] = '{55'h3, 1'b0};
    vecs[2] = '{{55{1'b1}}, 1'b1};
    vecs[3] = '{55'h0, 1'b0};
    vecs[4] = '{55'h2A, 1'b1};
    vecs[5] = '{55'h55, 1'b0};
    vecs[6] = '{55'h0123456789ABCD, 1'b1};

    #12;
    checkOutput("reset_sdata", 64'(S_Data), 64'd1);
    checkOutput("reset_ready", 64'(TX_Ready), 64'd1);
    TX_Data_Valid = 1'b1;
    repeat (2) @(posedge Clk_S);
    #1;
    checkOutput("reset_ignores_valid", 64'({S_Data, TX_Ready}), 64'd3);
    TX_Data_Valid = 1'b0;
    @(negedge Clk_S);
    Rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      waitReady($sformatf("vec%0d_ready", v));
      applyStimulus(vecs[v].data, 1'b0);
      captureFrame(f1, r1, s1, 1'b0);
      checkOutput($sformatf("vec%0d_frame", v), 64'(f1), 64'(frameOf(vecs[v].data, vecs[v].parity)));
      checkOutput($sformatf("vec%0d_parity", v), 64'(f1[1]), 64'(vecs[v].parity));
      checkOutput($sformatf("vec%0d_ready_low", v), 64'(r1), 64'd1);
      @(negedge Clk_S);
      checkOutput($sformatf("vec%0d_idle", v), 64'({S_Data, TX_Ready}), 64'd3);
    end

    waitReady("b2b_ready");
    applyStimulus(55'h2A, 1'b1);
    TX_Data = 55'h55;
    captureFrame(f1, r1, s1, 1'b0);
    @(negedge Clk_S);
    checkOutput("b2b_idle_gap", 64'({S_Data, TX_Ready}), 64'd3);
    @(posedge Clk_S);
    #1;
    TX_Data_Valid = 1'b0;
    captureFrame(f2, r2, s2, 1'b0);
    checkOutput("b2b_frame1", 64'(f1), 64'(frameOf(55'h2A, 1'b1)));
    checkOutput("b2b_frame2", 64'(f2), 64'(frameOf(55'h55, 1'b0)));
    checkOutput("b2b_period", 64'(s2 - s1), 64'd59);
    checkOutput("b2b_ready_low", 64'({r1, r2}), 64'd3);

    waitReady("stable_ready");
    applyStimulus(55'h0, 1'b0);
    TX_Data = 55'h7FFFFFFFFFFFFF;
    captureFrame(f1, r1, s1, 1'b1);
    checkOutput("stable_frame", 64'(f1), 64'(frameOf(55'h0, 1'b0)));
    checkOutput("stable_ready_low", 64'(r1), 64'd1);
    @(negedge Clk_S);
    checkOutput("stable_idle", 64'({S_Data, TX_Ready}), 64'd3);

    waitReady("rst_ready");
    applyStimulus(55'h0, 1'b0);
    TX_Data = {55{1'b1}};
    repeat (22) @(negedge Clk_S);
    checkOutput("rst_mid_bit20", 64'({S_Data, TX_Ready}), 64'd0);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("rst_immediate", 64'({S_Data, TX_Ready}), 64'd3);
    @(posedge Clk_S);
    @(negedge Clk_S);
    Rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge Clk_S);
      if (S_Data !== 1'b1 || TX_Ready !== 1'b1) ok = 1'b0;
    end
    checkOutput("rst_stays_idle", 64'(ok), 64'd1);

    for (int k = 0; k < 3; k++) begin
      pkt = 55'({$urandom, $urandom});
      waitReady($sformatf("loop%0d_ready", k));
      applyStimulus(pkt, 1'b0);
      ok = 1'b0;
      f1 = '0;
      for (int i = 0; i < 80 && !ok; i++) begin
        @(negedge Clk_S);
        #1;
        if (rxValid) begin
          ok = 1'b1;
          f1 = 58'(rxData);
        end
      end
      checkOutput($sformatf("loop%0d_rx_valid", k), 64'(ok), 64'd1);
      checkOutput($sformatf("loop%0d_rx_data", k), 64'(f1), 64'(pkt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
